fetch_packet_queue: RTL and testbench
=====================================

// Module: fetch_packet_queue
// PURPOSE
// - Parametrised multi-wide instruction queue between instruction_memory and issue_controller.
// - Decouples FETCH_WIDTH-wide fetch from NUM_SICS-wide dispatch.
// - Tags every word with a monotonically increasing issue id.
// - Discards all contents on rollback.
// PARAMETERS
// FETCH_WIDTH  2   words offered per enqueue beat
// NUM_SICS     2   dequeue ports, one per SIC
// DEPTH        8   entries; power of 2, >= FETCH_WIDTH and >= NUM_SICS
// ID_WIDTH     16  issue id width
// PORTS
// clk          in   1                    clock, rising edge
// rst_n        in   1                    async active-low reset
// flush        in   1                    rollback; empties queue
// enq_valid    in   1                    enqueue beat offered
// enq_count    in   clog2(FETCH_WIDTH+1) valid words in beat, 1..FETCH_WIDTH
// enq_pc       in   32                   byte PC of word 0; word k at enq_pc+4k
// enq_instr    in   [FETCH_WIDTH][32]    instruction words, index 0 oldest
// enq_ready    out  1                    free slots >= FETCH_WIDTH
// deq_req      in   [NUM_SICS]           SIC k requests an instruction
// deq_valid    out  [NUM_SICS]           grant to SIC k this cycle
// deq_pc       out  [NUM_SICS][32]       PC of granted word
// deq_instr    out  [NUM_SICS][32]       granted word
// deq_id       out  [NUM_SICS][ID_WIDTH] issue id of granted word
// occupancy    out  clog2(DEPTH+1)       entries held
// BEHAVIOUR
// - Storage: circular buffer; head, tail and count registers; pointers wrap modulo DEPTH.
// - Reset (async): head=tail=count=0; next_id=0; all deq_* = 0; enq_ready=1; occupancy=0.
// - Enqueue:
//   - Accepted at edge iff enq_valid && enq_ready && !flush.
//   - Writes enq_count words at tail, with ids next_id .. next_id+enq_count-1.
//   - next_id wraps modulo 2^ID_WIDTH.
//   - Ignored if enq_valid && !enq_ready: no partial write; source holds the beat.
//   - enq_count = 0 or > FETCH_WIDTH: beat ignored.
// - enq_ready: combinational, (DEPTH - count) >= FETCH_WIDTH, from start-of-cycle count.
//   - No credit for same-cycle dequeues.
// - Dequeue (combinational grant, pop at edge):
//   - Requesters ranked by ascending SIC index; the r-th requester gets entry head+r iff r < count.
//   - Ungranted requesters see deq_valid=0; their pc/instr/id read 0.
//   - Grants are contiguous oldest-first; head advances by the number of grants.
//   - No bypass: words enqueued in cycle t are grantable from t+1.
// - Simultaneous enq+deq: count_next = count + enq_n - deq_n. Full and empty are exact.
// - flush:
//   - Forces deq_valid=0 and blocks enqueue in the same cycle.
//   - Next edge: head=tail=count=0.
//   - next_id is NOT reset, so ids stay unique across rollbacks.
// - Id uniqueness: at most DEPTH ids are live, requiring 2^ID_WIDTH > DEPTH (elaboration assert).
// - occupancy = count; registered.
// CONFIGURATION
// - FETCH_QUEUE_STATS_EN defined: adds outputs
//   - stat_hwm   clog2(DEPTH+1): max occupancy since reset; flush does not clear it.
//   - stat_stall 32: cycles with enq_valid && !enq_ready; saturates at 32'hFFFF_FFFF.
// - Undefined: those ports and their registers do not exist. Core behaviour is identical.
// TESTING
// - Reset then enq beat {pc=0x3000, count=2} -> next cycle, req both SICs:
//   - SIC0 gets 0x3000 id0; SIC1 gets 0x3004 id1; occupancy 2->0.
// - Fill DEPTH=8 with 4 beats, no deq -> occupancy 8, enq_ready=0.
//   - 5th beat held: no write; stat_stall increments per cycle.
// - Queue holds 1 entry, deq_req=2'b10 -> SIC1 granted that entry.
//   - Same cycle deq_req=2'b11 variant: SIC0 granted, SIC1 deq_valid=0.
// - Entries 3 + same-cycle enq 2 + deq 2 -> occupancy 3.
//   - Tail wraps 7->1 with correct word order on later dequeue.
// - flush with enq_valid and deq_req active -> no grants; next cycle occupancy 0.
//   - Following beat gets id continuing from the pre-flush next_id.
// - Run 2^16+3 words through -> ids wrap 0xFFFF->0x0000, no gap; async rst_n mid-stream clears all.

Source files
------------

// File: rtl/fetch_packet_queue_if.sv
// Bus bundle between the fetch side / issue side and the fetch packet queue.
// Enqueue: enq_valid, enq_count, enq_pc, enq_instr -> enq_ready
// Dequeue: deq_req -> deq_valid, deq_pc, deq_instr, deq_id
// Status : occupancy
// The slave modport is the queue's view; master is the driver's view.
interface fetch_packet_queue_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned NUM_SICS    = 2,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ID_WIDTH    = 16
);
    localparam int unsigned EC_W  = $clog2(FETCH_WIDTH + 1);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                                enq_valid;
    logic [EC_W-1:0]                     enq_count;
    logic [31:0]                         enq_pc;
    logic [FETCH_WIDTH-1:0][31:0]        enq_instr;
    logic                                enq_ready;
    logic [NUM_SICS-1:0]                 deq_req;
    logic [NUM_SICS-1:0]                 deq_valid;
    logic [NUM_SICS-1:0][31:0]           deq_pc;
    logic [NUM_SICS-1:0][31:0]           deq_instr;
    logic [NUM_SICS-1:0][ID_WIDTH-1:0]   deq_id;
    logic [OCC_W-1:0]                    occupancy;

    modport master (
        output enq_valid, enq_count, enq_pc, enq_instr, deq_req,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_id, occupancy
    );

    modport slave (
        input  enq_valid, enq_count, enq_pc, enq_instr, deq_req,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_id, occupancy
    );
endinterface

// File: rtl/fetch_packet_queue.sv
// Multi-wide instruction queue between instruction memory and the issue
// controller. Accepts up to FETCH_WIDTH words per beat, hands out up to
// NUM_SICS words per cycle oldest-first, tags each word with a wrapping
// issue id, and discards everything on flush (ids keep counting).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   flush       rollback: no grants, no enqueue, queue empty after the edge
//   bus         fetch_packet_queue_if.slave (enqueue beat, dequeue grants,
//               occupancy)
// Optional: define FETCH_QUEUE_STATS_EN to add stat_hwm (max occupancy since
// reset) and stat_stall (saturating count of enq_valid && !enq_ready cycles).
module fetch_packet_queue #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned NUM_SICS    = 2,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ID_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    fetch_packet_queue_if.slave        bus
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] stat_hwm,
    output logic [31:0]                stat_stall
`endif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned EC_W  = $clog2(FETCH_WIDTH + 1);

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_packet_queue: DEPTH must be a power of 2 and >= 2");
    end
    if (DEPTH < FETCH_WIDTH || DEPTH < NUM_SICS) begin : g_bad_width
        $error("fetch_packet_queue: DEPTH must be >= FETCH_WIDTH and >= NUM_SICS");
    end
    if (ID_WIDTH <= $clog2(DEPTH)) begin : g_bad_id
        $error("fetch_packet_queue: 2**ID_WIDTH must exceed DEPTH for unique live ids");
    end

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ID_WIDTH-1:0] next_id_q, next_id_d;

    logic [31:0]         mem_pc_q    [DEPTH];
    logic [31:0]         mem_instr_q [DEPTH];
    logic [ID_WIDTH-1:0] mem_id_q    [DEPTH];

    logic                enq_ready_c;
    logic                enq_fire_c;
    logic [CNT_W-1:0]    enq_n_c;
    logic [CNT_W-1:0]    deq_n_c;
    logic [CNT_W-1:0]    rank_c;
    logic [PTR_W-1:0]    rd_idx_c;

    // Ready only when a full-width beat fits in start-of-cycle free space
    assign enq_ready_c   = count_q <= CNT_W'(DEPTH - FETCH_WIDTH);
    assign bus.enq_ready = enq_ready_c;
    assign bus.occupancy = count_q;

    // Dequeue grants: r-th requester (ascending SIC index) gets entry head+r
    always_comb begin
        bus.deq_valid = '0;
        bus.deq_pc    = '0;
        bus.deq_instr = '0;
        bus.deq_id    = '0;
        rank_c        = '0;
        rd_idx_c      = head_q;
        for (int k = 0; k < NUM_SICS; k++) begin
            if (bus.deq_req[k] && !flush && rank_c < count_q) begin
                rd_idx_c         = head_q + PTR_W'(rank_c);
                bus.deq_valid[k] = 1'b1;
                bus.deq_pc[k]    = mem_pc_q[rd_idx_c];
                bus.deq_instr[k] = mem_instr_q[rd_idx_c];
                bus.deq_id[k]    = mem_id_q[rd_idx_c];
                rank_c           = rank_c + CNT_W'(1);
            end
        end
        deq_n_c = rank_c;
    end

    // Pointer / count / id update
    always_comb begin
        enq_fire_c = bus.enq_valid && enq_ready_c && !flush &&
                     (bus.enq_count != '0) && (bus.enq_count <= EC_W'(FETCH_WIDTH));
        enq_n_c    = enq_fire_c ? CNT_W'(bus.enq_count) : '0;
        head_d     = head_q + PTR_W'(deq_n_c);
        tail_d     = tail_q + PTR_W'(enq_n_c);
        count_d    = count_q + enq_n_c - deq_n_c;
        next_id_d  = next_id_q + ID_WIDTH'(enq_n_c);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            next_id_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            next_id_q <= next_id_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (enq_fire_c) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (EC_W'(k) < bus.enq_count) begin
                    mem_pc_q[tail_q + PTR_W'(k)]    <= bus.enq_pc + (32'(k) << 2);
                    mem_instr_q[tail_q + PTR_W'(k)] <= bus.enq_instr[k];
                    mem_id_q[tail_q + PTR_W'(k)]    <= next_id_q + ID_WIDTH'(k);
                end
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [CNT_W-1:0] stat_hwm_q, stat_hwm_d;
    logic [31:0]      stat_stall_q, stat_stall_d;

    // High-water mark tracks the occupancy value being registered
    always_comb begin
        stat_hwm_d   = (count_d > stat_hwm_q) ? count_d : stat_hwm_q;
        stat_stall_d = stat_stall_q;
        if (bus.enq_valid && !enq_ready_c && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hwm_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_hwm_q   <= stat_hwm_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_hwm   = stat_hwm_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Randomised bench for fetch_packet_queue against a queue-based reference
// model, plus directed scenarios with hand-computed expectations.
module tb_fetch_packet_queue;
    localparam int FW    = 2;
    localparam int NS    = 2;
    localparam int DEPTH = 8;
    localparam int IDW   = 16;

    typedef struct packed {
        logic [31:0]    pc;
        logic [31:0]    instr;
        logic [IDW-1:0] id;
    } ent_t;

    logic clk;
    logic rst_n;
    logic flush;

    fetch_packet_queue_if #(.FETCH_WIDTH(FW), .NUM_SICS(NS), .DEPTH(DEPTH), .ID_WIDTH(IDW)) bus();

`ifdef FETCH_QUEUE_STATS_EN
    logic [3:0]  stat_hwm;
    logic [31:0] stat_stall;
`endif

    fetch_packet_queue #(.FETCH_WIDTH(FW), .NUM_SICS(NS), .DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_hwm   (stat_hwm),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq[$];
    int unsigned m_next_id;
    int          m_hwm;
    logic [31:0] m_stall;
    longint      words_in;
    logic [15:0] last_id;
    bit          have_last;
    bit          saw_wrap;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next_id = 0;
        m_hwm     = 0;
        m_stall   = '0;
        have_last = 1'b0;
    endtask

    // One cycle: drive at negedge, compare combinational/registered outputs
    // against the model, then advance the model to what the edge will do.
    task automatic step(input logic fl, input logic ev, input logic [1:0] cnt,
                        input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] req);
        int   sz;
        int   rank;
        int   ngrant;
        bit   rdy;
        logic [1:0] v_exp;
        ent_t e;
        @(negedge clk);
        flush            = fl;
        bus.enq_valid    = ev;
        bus.enq_count    = cnt;
        bus.enq_pc       = pc;
        bus.enq_instr[0] = i0;
        bus.enq_instr[1] = i1;
        bus.deq_req      = req;
        #1;
        sz     = mq.size();
        rdy    = (DEPTH - sz) >= FW;
        rank   = 0;
        ngrant = 0;
        v_exp  = '0;
        for (int k = 0; k < NS; k++) begin
            e = '0;
            if (req[k]) begin
                if (!fl && rank < sz) begin
                    e        = mq[rank];
                    v_exp[k] = 1'b1;
                    ngrant++;
                end
                rank++;
            end
            chk($sformatf("deq_pc[%0d]", k),    64'(bus.deq_pc[k]),    64'(e.pc));
            chk($sformatf("deq_instr[%0d]", k), 64'(bus.deq_instr[k]), 64'(e.instr));
            chk($sformatf("deq_id[%0d]", k),    64'(bus.deq_id[k]),    64'(e.id));
            if (bus.deq_valid[k] === 1'b1) begin
                if (have_last && last_id == 16'hFFFF && bus.deq_id[k] == 16'h0000) saw_wrap = 1'b1;
                last_id   = bus.deq_id[k];
                have_last = 1'b1;
            end
        end
        chk("deq_valid", 64'(bus.deq_valid), 64'(v_exp));
        chk("enq_ready", 64'(bus.enq_ready), 64'(rdy));
        chk("occupancy", 64'(bus.occupancy), 64'(sz));
`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_hwm",   64'(stat_hwm),   64'(m_hwm));
        chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
        if (ev && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            for (int g = 0; g < ngrant; g++) void'(mq.pop_front());
            if (ev && rdy && cnt >= 1 && cnt <= FW) begin
                for (int w = 0; w < int'(cnt); w++) begin
                    mq.push_back('{pc: pc + 32'(4 * w), instr: (w == 0) ? i0 : i1, id: 16'(m_next_id)});
                    m_next_id = (m_next_id + 1) % 65536;
                    words_in++;
                end
            end
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic rand_step();
        logic       fl;
        logic       ev;
        logic [1:0] cnt;
        fl  = ($urandom_range(0, 39) == 0);
        ev  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) cnt = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
        else                            cnt = 2'($urandom_range(1, 2));
        step(fl, ev, cnt, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        words_in  = 0;
        saw_wrap  = 1'b0;
        last_id   = '0;
        model_reset();
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus.enq_valid    = 1'b0;
        bus.enq_count    = '0;
        bus.enq_pc       = '0;
        bus.enq_instr[0] = '0;
        bus.enq_instr[1] = '0;
        bus.deq_req      = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        // Reset state, with requests asserted
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("rst_deq_id",    64'(bus.deq_id),    64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // First beat, then both SICs drain it
        step(1'b0, 1'b1, 2'd2, 32'h3000, 32'hA000_0000, 32'hA000_0001, 2'b11);
        chk("nobypass_valid", 64'(bus.deq_valid), 64'd0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
        chk("first_valid", 64'(bus.deq_valid),  64'h3);
        chk("first_pc0",   64'(bus.deq_pc[0]),  64'h3000);
        chk("first_id0",   64'(bus.deq_id[0]),  64'd0);
        chk("first_pc1",   64'(bus.deq_pc[1]),  64'h3004);
        chk("first_id1",   64'(bus.deq_id[1]),  64'd1);
        chk("first_occ",   64'(bus.occupancy),  64'd2);
        idle();
        chk("drained_occ", 64'(bus.occupancy), 64'd0);

        // Fill to DEPTH (ids 2..9), then hold a beat for three cycles
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 2'd2, 32'h4000 + 32'(8 * i), 32'(i), 32'(i + 100), 2'b00);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'd2, 32'h5F00, 32'hDEAD, 32'hBEEF, 2'b00);
        chk("full_occ",   64'(bus.occupancy), 64'd8);
        chk("full_ready", 64'(bus.enq_ready), 64'd0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stall_3", 64'(stat_stall), 64'd3);
        chk("hwm_8",   64'(stat_hwm),   64'd8);
`endif
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b01);
        // One entry left (id 9); only SIC1 requests
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b10);
        chk("sic1_valid", 64'(bus.deq_valid), 64'h2);
        chk("sic1_id",    64'(bus.deq_id[1]), 64'd9);
        chk("sic1_pc",    64'(bus.deq_pc[1]), 64'h401C);
        // One entry (id 10); both request, only SIC0 wins
        step(1'b0, 1'b1, 2'd1, 32'h5000, 32'h1234, 32'd0, 2'b00);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
        chk("one_valid", 64'(bus.deq_valid), 64'h1);
        chk("one_id",    64'(bus.deq_id[0]), 64'd10);
        chk("one_pc",    64'(bus.deq_pc[0]), 64'h5000);
        // 3 entries + enq 2 + deq 2 in the same cycle
        step(1'b0, 1'b1, 2'd2, 32'h5100, 32'h11, 32'h12, 2'b00);
        step(1'b0, 1'b1, 2'd1, 32'h5200, 32'h13, 32'd0,  2'b00);
        step(1'b0, 1'b1, 2'd2, 32'h5300, 32'h14, 32'h15, 2'b11);
        chk("simul_id0", 64'(bus.deq_id[0]), 64'd11);
        idle();
        chk("simul_occ", 64'(bus.occupancy), 64'd3);
        // Flush with enqueue and requests active
        step(1'b1, 1'b1, 2'd2, 32'h6000, 32'h66, 32'h67, 2'b11);
        chk("flush_valid", 64'(bus.deq_valid), 64'd0);
        idle();
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        step(1'b0, 1'b1, 2'd1, 32'h7000, 32'h77, 32'd0, 2'b00);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b01);
        chk("postflush_id", 64'(bus.deq_id[0]), 64'd16);
        chk("postflush_pc", 64'(bus.deq_pc[0]), 64'h7000);

        // Random traffic
        for (int c = 0; c < 3000; c++) rand_step();

        // Push well past 2^16 words so the id wraps through 0xFFFF
        begin
            longint target;
            target = words_in + 65539 + 16;
            for (int c = 0; c < 45000 && words_in < target; c++) begin
                step(1'b0, 1'b1, 2'd2, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                     ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11);
            end
            chk("wrap_words_reached", 64'(words_in >= target), 64'd1);
        end
        chk("id_wrap_seen", 64'(saw_wrap), 64'd1);

        // Async reset mid-stream while requests are pending
        step(1'b0, 1'b1, 2'd2, 32'h8000, 32'h1, 32'h2, 2'b00);
        @(negedge clk);
        bus.deq_req   = 2'b11;
        bus.enq_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_occ",   64'(bus.occupancy), 64'd0);
        chk("arst_valid", 64'(bus.deq_valid), 64'd0);
        chk("arst_ready", 64'(bus.enq_ready), 64'd1);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
`ifdef FETCH_QUEUE_STATS_EN
        #1;
        chk("arst_hwm",   64'(stat_hwm),   64'd0);
        chk("arst_stall", 64'(stat_stall), 64'd0);
`endif
        step(1'b0, 1'b1, 2'd2, 32'h9000, 32'h91, 32'h92, 2'b00);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 2'b11);
        chk("arst_id0", 64'(bus.deq_id[0]), 64'd0);
        chk("arst_id1", 64'(bus.deq_id[1]), 64'd1);
        chk("arst_pc1", 64'(bus.deq_pc[1]), 64'h9004);
        for (int c = 0; c < 200; c++) rand_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
